// File: rtl/fetch_unit.sv
// fetch_unit: program-counter sequencing, syscall halt/resume control and
// execution counters for a single-cycle MIPS-style core.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        bneorbeq,
  input  logic        isjr,
  input  logic        isjal,
  input  logic        issyscall,
  input  logic        equal,
  input  logic [31:0] rs_val,
  input  logic [31:0] v0_val,
  input  logic        go,
  output logic [31:0] pc,
  output logic [9:0]  imem_addr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] taken_count,
  output logic [31:0] uncond_count
);

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] taken_q, taken_d;
  logic [31:0] uncond_q, uncond_d;
  logic        brtaken_s, jmp_s, halt_req_s;
  logic [31:0] pc_plus4_s, jmp_target_s, br_target_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // jal shares the j target, so either flag selects the jump path
  assign jmp_s        = jump | isjal;
  assign brtaken_s    = branch & (bneorbeq ? ~equal : equal);
  assign pc_plus4_s   = pc_q + 32'd4;
  assign jmp_target_s = {pc_plus4_s[31:28], instr[25:0], 2'b00};
  assign br_target_s  = pc_plus4_s + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign halt_req_s   = issyscall & ~(isjr | jmp_s | brtaken_s) & (v0_val == 32'd10);

  // next-state, next-pc and counter update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cycle_d  = cycle_q;
    taken_d  = taken_q;
    uncond_d = uncond_q;
    case (state_q)
      RUN: begin
        cycle_d = sat_inc(cycle_q);
        if (isjr) begin
          pc_d = rs_val;
        end else if (jmp_s) begin
          pc_d = jmp_target_s;
        end else if (brtaken_s) begin
          pc_d = br_target_s;
        end else if (halt_req_s) begin
          pc_d    = pc_q;
          state_d = HALT;
        end else begin
          pc_d = pc_plus4_s;
        end
        if (isjr | jmp_s) begin
          uncond_d = sat_inc(uncond_q);
        end else if (brtaken_s) begin
          taken_d = sat_inc(taken_q);
        end else begin
          uncond_d = uncond_q;
        end
      end
      HALT: begin
        if (go) begin
          state_d = RUN;
          pc_d    = pc_plus4_s;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // state, pc and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= 32'h0000_0000;
      cycle_q  <= 32'd0;
      taken_q  <= 32'd0;
      uncond_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cycle_q  <= cycle_d;
      taken_q  <= taken_d;
      uncond_q <= uncond_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_s;
  assign imem_addr    = pc_q[11:2];
  assign op           = instr[31:26];
  assign func         = instr[5:0];
  assign halted       = (state_q == HALT);
  assign cycle_count  = cycle_q;
  assign taken_count  = taken_q;
  assign uncond_count = uncond_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run, both checked
// against a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rs_val, v0_val;
  logic        jump, branch, bneorbeq, isjr, isjal, issyscall, equal, go;
  logic [31:0] pc, pc_plus4, cycle_count, taken_count, uncond_count;
  logic [9:0]  imem_addr;
  logic [5:0]  op, func;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_cyc, m_taken, m_unc;
  logic        m_halted;

  fetch_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .jump(jump), .branch(branch),
    .bneorbeq(bneorbeq), .isjr(isjr), .isjal(isjal), .issyscall(issyscall),
    .equal(equal), .rs_val(rs_val), .v0_val(v0_val), .go(go), .pc(pc),
    .imem_addr(imem_addr), .op(op), .func(func), .pc_plus4(pc_plus4),
    .halted(halted), .cycle_count(cycle_count), .taken_count(taken_count),
    .uncond_count(uncond_count)
  );

  always #5 clk = ~clk;

  // flags order: {jump, branch, bneorbeq, isjr, isjal, issyscall, equal}
  typedef struct {
    logic [31:0] instr;
    logic [6:0]  flags;
    logic [31:0] rs_val;
    logic [31:0] v0_val;
    logic        go;
    logic [31:0] exp_pc;
    logic        exp_halted;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(input logic [31:0] i, input logic [6:0] f, input logic [31:0] rs,
                              input logic [31:0] v0, input logic g, input logic [31:0] epc,
                              input logic eh);
    vec_t v;
    v.instr = i; v.flags = f; v.rs_val = rs; v.v0_val = v0; v.go = g;
    v.exp_pc = epc; v.exp_halted = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_cyc = 32'd0; m_taken = 32'd0; m_unc = 32'd0; m_halted = 1'b0;
  endtask

  // one rising edge of the architectural rules
  task automatic model_edge();
    logic        taken, uncond;
    logic [31:0] seq;
    int          off;
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
      if (go) begin
        m_halted = 1'b0;
        m_pc = m_pc + 32'd4;
      end
    end else begin
      seq = m_pc + 32'd4;
      taken = branch && (bneorbeq ? !equal : equal);
      uncond = isjr || jump || isjal;
      m_cyc = sat(m_cyc);
      if (uncond) m_unc = sat(m_unc);
      else if (taken) m_taken = sat(m_taken);
      if (isjr) m_pc = rs_val;
      else if (jump || isjal) m_pc = (seq & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
      else if (taken) begin
        off = int'($signed(instr[15:0]));
        m_pc = seq + 32'(off * 4);
      end else if (issyscall && v0_val == 32'd10) m_halted = 1'b1;
      else m_pc = seq;
    end
  endtask

  task automatic check_state();
    chk("pc", pc, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("cycle_count", cycle_count, m_cyc);
    chk("taken_count", taken_count, m_taken);
    chk("uncond_count", uncond_count, m_unc);
  endtask

  task automatic check_comb();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    chk("pc_plus4", pc_plus4, p4);
    chk("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
    chk("op", {26'd0, op}, {26'd0, instr[31:26]});
    chk("func", {26'd0, func}, {26'd0, instr[5:0]});
  endtask

  // called just after a sample point; one full cycle
  task automatic apply_cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic drive(input vec_t v);
    {jump, branch, bneorbeq, isjr, isjal, issyscall, equal} = v.flags;
    instr = v.instr; rs_val = v.rs_val; v0_val = v.v0_val; go = v.go;
  endtask

  localparam logic [31:0] NOP   = 32'h0000_0020;
  localparam logic [31:0] BEQM4 = 32'h1022_FFFC;
  localparam logic [31:0] BNE3  = 32'h1422_0003;
  localparam logic [31:0] BEQ1  = 32'h1022_0001;
  localparam logic [31:0] JAL   = 32'h0C00_0040;
  localparam logic [31:0] JR    = 32'h0200_0008;
  localparam logic [31:0] SYS   = 32'h0000_000C;
  localparam logic [6:0]  F_NONE = 7'b0000000;
  localparam logic [6:0]  F_JR   = 7'b0001000;
  localparam logic [6:0]  F_JAL  = 7'b1000100;
  localparam logic [6:0]  F_SYS  = 7'b0000010;

  initial begin
    tbl[0]  = mk(NOP,   F_NONE,     32'd0, 32'd0, 1'b0, 32'h0000_0004, 1'b0);
    tbl[1]  = mk(NOP,   F_NONE,     32'd0, 32'd0, 1'b0, 32'h0000_0008, 1'b0);
    tbl[2]  = mk(NOP,   F_NONE,     32'd0, 32'd0, 1'b0, 32'h0000_000C, 1'b0);
    tbl[3]  = mk(JR,    F_JR,       32'h10, 32'd0, 1'b0, 32'h0000_0010, 1'b0);
    tbl[4]  = mk(BEQM4, 7'b0100001, 32'd0, 32'd0, 1'b0, 32'h0000_0004, 1'b0);
    tbl[5]  = mk(JR,    F_JR,       32'h10, 32'd0, 1'b0, 32'h0000_0010, 1'b0);
    tbl[6]  = mk(BEQM4, 7'b0100000, 32'd0, 32'd0, 1'b0, 32'h0000_0014, 1'b0);
    tbl[7]  = mk(JR,    F_JR,       32'h20, 32'd0, 1'b0, 32'h0000_0020, 1'b0);
    tbl[8]  = mk(BNE3,  7'b0110000, 32'd0, 32'd0, 1'b0, 32'h0000_0030, 1'b0);
    tbl[9]  = mk(JR,    F_JR,       32'h20, 32'd0, 1'b0, 32'h0000_0020, 1'b0);
    tbl[10] = mk(JAL,   F_JAL,      32'd0, 32'd0, 1'b0, 32'h0000_0100, 1'b0);
    tbl[11] = mk(JR,    F_JR,       32'h200, 32'd0, 1'b0, 32'h0000_0200, 1'b0);
    tbl[12] = mk(JR,    F_JR,       32'hFFFF_FFFC, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    tbl[13] = mk(NOP,   F_NONE,     32'd0, 32'd0, 1'b0, 32'h0000_0000, 1'b0);
    tbl[14] = mk(JR,    F_JR,       32'h40, 32'd0, 1'b0, 32'h0000_0040, 1'b0);
    tbl[15] = mk(SYS,   F_SYS,      32'd0, 32'd10, 1'b0, 32'h0000_0040, 1'b1);
    for (int k = 16; k <= 20; k++)
      tbl[k] = mk(NOP,  F_NONE,     32'd0, 32'd10, 1'b0, 32'h0000_0040, 1'b1);
    tbl[21] = mk(NOP,   F_NONE,     32'd0, 32'd0, 1'b1, 32'h0000_0044, 1'b0);
    tbl[22] = mk(JR,    F_JR,       32'h40, 32'd0, 1'b0, 32'h0000_0040, 1'b0);
    tbl[23] = mk(SYS,   F_SYS,      32'd0, 32'd4, 1'b0, 32'h0000_0044, 1'b0);
    tbl[24] = mk(BEQ1,  7'b0100011, 32'd0, 32'd10, 1'b0, 32'h0000_004C, 1'b0);
    tbl[25] = mk(JR,    F_JR,       32'h40, 32'd0, 1'b1, 32'h0000_0040, 1'b0);
    tbl[26] = mk(SYS,   F_SYS,      32'd0, 32'd10, 1'b0, 32'h0000_0040, 1'b1);

    rst = 1'b1;
    drive(mk(NOP, F_NONE, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i]);
      if (i == 10) begin
        #1;
        chk("jal_pc_plus4", pc_plus4, 32'h0000_0024);
        apply_cycle();
      end else begin
        apply_cycle();
      end
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_halted", {31'd0, halted}, {31'd0, tbl[i].exp_halted});
      if (i == 2)  chk("seq_cycles", cycle_count, 32'd3);
      if (i == 4)  chk("beq_taken", taken_count, 32'd1);
      if (i == 6)  chk("beq_not_taken", taken_count, 32'd1);
      if (i == 11) begin
        chk("cnt_cycles", cycle_count, 32'd12);
        chk("cnt_taken", taken_count, 32'd2);
        chk("cnt_uncond", uncond_count, 32'd6);
      end
      if (i == 20) chk("halt_frozen_cycles", cycle_count, 32'd16);
    end

    // asynchronous reset between edges while halted, go held high
    #2;
    rst = 1'b1;
    go = 1'b1;
    #1;
    model_reset();
    chk("arst_pc", pc, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_cycles", cycle_count, 32'd0);
    chk("arst_taken", taken_count, 32'd0);
    chk("arst_uncond", uncond_count, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_go_ignored", pc, 32'd0);
    rst = 1'b0;
    drive(mk(NOP, F_NONE, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0));
    apply_cycle();
    chk("restart_pc", pc, 32'h0000_0004);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      int cls;
      cls = $urandom_range(0, 9);
      instr = $urandom;
      rs_val = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      v0_val = ($urandom_range(0, 1) == 0) ? 32'd10 : $urandom_range(0, 20);
      go = ($urandom_range(0, 3) == 0);
      {jump, branch, bneorbeq, isjr, isjal, issyscall, equal} = 7'd0;
      equal = $urandom_range(0, 1);
      bneorbeq = $urandom_range(0, 1);
      case (cls)
        4, 5: branch = 1'b1;
        6: begin jump = 1'b1; isjal = $urandom_range(0, 1); end
        7: begin isjr = 1'b1; jump = $urandom_range(0, 1); branch = $urandom_range(0, 1); end
        8: issyscall = 1'b1;
        9: {jump, branch, isjr, isjal, issyscall} = 5'($urandom);
        default: ;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_state();
        rst = 1'b0;
      end
      apply_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
